ahblite_tone_seq: RTL
=====================

// Module: ahblite_tone_seq
// PURPOSE
//  AHB-Lite slave: NUM_CH independent square-wave tone channels for the buzzer/speaker pins.
//  Each channel plays notes {duration, half-period} queued in its own FIFO, so CPU sets up melodies without polling.
//  Successor to the single-enable buzzer; adds per-channel queueing, programmable pitch/duration, rests, flush and IRQ.
// PARAMETERS
//  NUM_CH      2      tone channels (1..4); channel index = HADDR[5:4]
//  FIFO_DEPTH  8      notes per channel FIFO (power of 2, >=2)
//  DIV_W       20     half-period counter width (HCLK cycles)
//  DUR_W       12     note duration width (ticks)
//  TICK_DIV    50000  HCLK cycles per duration tick (1 ms @ 50 MHz)
// PORTS
//  HCLK       in   1        system clock
//  HRESETn    in   1        synchronous active-low reset
//  HSEL, HADDR[31:0], HTRANS[1:0], HSIZE[2:0], HPROT[3:0], HWRITE, HWDATA[31:0], HREADY  in  standard AHB-Lite
//  HREADYOUT  out  1        always 1 (zero wait states)
//  HRDATA     out  32       read data
//  HRESP      out  1        always 0 (OKAY)
//  beep       out  NUM_CH   per-channel square wave
//  irq        out  1        OR of (done_flag & done_ie) over channels
// BEHAVIOUR
//  Bus: address phase captured when HSEL&HTRANS[1]&HREADY; write commits on next cycle using HWDATA; read data driven
//   combinationally in data phase from captured address. No read side effects. Offsets per channel (HADDR[3:2]):
//   0x0 CTRL  RW  [0]en [1]done_ie [2]flush (W1, self-clears, reads 0)
//   0x4 NOTE  WO  [DIV_W-1:0] half-period (0 = rest), [DUR_W+19:20] duration ticks (0 = note skipped); reads 0
//   0x8 STAT  RO  [0]busy [1]empty [2]full [3]ovf [4]done [15:8]fifo count
//   0xC CLR   W1C [3]ovf [4]done
//  Reset (HRESETn=0 at HCLK edge): CTRL=0, FIFOs empty, ovf=done=0, all FSMs IDLE, beep=0, irq=0, tick prescaler=0.
//  Tick prescaler: shared, counts 0..TICK_DIV-1 continuously, 1-cycle tick pulse at wrap.
//  Channel FSM: IDLE -> LOAD when en & !empty; LOAD (1 cycle): pop head, latch div/dur, clear half/dur counters -> PLAY.
//   PLAY: half-counter counts HCLK; at div-1 toggles beep and restarts; div=0 holds beep=0 (rest).
//   dur decrements on each tick; at 0 -> LOAD if !empty else IDLE and set done; beep forced 0 on leaving PLAY.
//   Note with dur=0: popped in LOAD, returns to LOAD/IDLE next cycle, beep never toggles.
//   busy = (state != IDLE).
//  en cleared mid-note: next cycle IDLE, beep=0, current note discarded, FIFO kept. flush: FIFO emptied, current note
//   aborted to IDLE, done NOT set. Write of CTRL with en=1 and flush=1: flush wins this cycle, en=1 stored.
//  FIFO: push on NOTE write; push when full is dropped and sets ovf (even if a pop occurs same cycle).
//   Simultaneous push and pop when not full: count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  Sticky flags: set wins over a W1C clear in the same cycle.
//  Accesses to channel index >= NUM_CH: writes ignored, reads 0. HSIZE/HPROT ignored (32-bit accesses only).
// STRUCTURE
//  Package tone_seq_pkg: register offsets, CTRL/STAT bit positions, FSM state enum {IDLE,LOAD,PLAY}.
//  Sub-module tone_channel (FIFO + FSM + counters), instantiated NUM_CH times via generate;
//   top holds AHB decode, tick prescaler, register mux, irq OR.
// TESTING (TICK_DIV=10 for sim)
//  1 Reset: drive bus idle, HRESETn=0 2 cycles -> beep=0, irq=0, STAT ch0 = 0x0002 (empty).
//  2 ch0 NOTE div=4 dur=3, CTRL=1 -> beep[0] toggles every 4 HCLK for 30 cycles (+/-1 tick phase), then busy=0, done=1.
//  3 Queue 3 notes (div 2, rest div 0, div 5), irq enabled -> correct periods in order, rest holds 0, irq asserted once after last; CLR 0x10 -> irq=0.
//  4 Push FIFO_DEPTH+1 notes with en=0 -> STAT full=1, ovf=1, count=FIFO_DEPTH; CLR 0x08 clears ovf only.
//  5 Mid-note en=0 then flush on ch1 while ch0 plays -> ch1 beep=0 next cycle, count=0, done=0; ch0 unaffected.
//  6 Assert HRESETn=0 mid-note -> next edge all outputs/registers at reset values; playback does not resume.

Source files
------------

// File: rtl/tone_seq_pkg.sv
// Shared definitions for the AHB-Lite tone sequencer: register offsets,
// CTRL/STAT bit positions and the channel state encoding.
package tone_seq_pkg;

    localparam logic [1:0] OFF_CTRL = 2'd0;
    localparam logic [1:0] OFF_NOTE = 2'd1;
    localparam logic [1:0] OFF_STAT = 2'd2;
    localparam logic [1:0] OFF_CLR  = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_IE    = 1;
    localparam int CTRL_FLUSH = 2;

    localparam int CLR_OVF  = 3;
    localparam int CLR_DONE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } ch_state_e;

endpackage

// File: rtl/tone_channel.sv
// One tone channel: note FIFO, IDLE/LOAD/PLAY sequencer, half-period and
// duration counters, sticky ovf/done flags. Current state is exported on state_dbg.
module tone_channel
    import tone_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 20,
    parameter int DUR_W      = 12
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             tick,
    input  logic             ctrl_we,
    input  logic [2:0]       ctrl_wdata,
    input  logic             note_we,
    input  logic [DIV_W-1:0] note_div,
    input  logic [DUR_W-1:0] note_dur,
    input  logic             clr_we,
    input  logic             clr_ovf,
    input  logic             clr_done,
    output logic             en,
    output logic             done_ie,
    output logic             busy,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             done,
    output logic [7:0]       count,
    output logic             beep,
    output ch_state_e        state_dbg
);

    localparam int PW = $clog2(FIFO_DEPTH);

    logic [DUR_W+DIV_W-1:0] mem [FIFO_DEPTH];
    logic [DUR_W+DIV_W-1:0] head;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            cnt;

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q, half_q;
    logic [DUR_W-1:0] dur_q;
    logic             en_eff, flush, abort, push, pop, done_set;

    // A CTRL write takes effect on the same edge it commits, so clearing en
    // or flushing leaves PLAY immediately.
    assign flush    = ctrl_we & ctrl_wdata[CTRL_FLUSH];
    assign en_eff   = ctrl_we ? ctrl_wdata[CTRL_EN] : en;
    assign abort    = flush | ~en_eff;
    assign empty    = (cnt == '0);
    assign full     = (cnt == (PW+1)'(FIFO_DEPTH));
    assign push     = note_we & ~full;
    assign pop      = (state_q == LOAD) & ~abort;
    assign done_set = (state_q == PLAY) & ~abort & (dur_q == '0) & empty;
    assign head     = mem[rd_ptr];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = LOAD;
            LOAD:    state_d = PLAY;
            PLAY:    if (dur_q == '0) state_d = empty ? IDLE : LOAD;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            en      <= 1'b0;
            done_ie <= 1'b0;
            ovf     <= 1'b0;
            done    <= 1'b0;
        end else begin
            if (ctrl_we) begin
                en      <= ctrl_wdata[CTRL_EN];
                done_ie <= ctrl_wdata[CTRL_IE];
            end
            // A set in the same cycle as a W1C clear keeps the flag.
            ovf  <= (note_we & full) | (ovf & ~(clr_we & clr_ovf));
            done <= done_set | (done & ~(clr_we & clr_done));
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr] <= {note_dur, note_div};
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            cnt <= cnt + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            div_q  <= '0;
            dur_q  <= '0;
            half_q <= '0;
            beep   <= 1'b0;
        end else begin
            if (state_q == LOAD) begin
                div_q  <= head[DIV_W-1:0];
                dur_q  <= head[DUR_W+DIV_W-1:DIV_W];
                half_q <= '0;
            end else if (state_q == PLAY) begin
                if (tick && dur_q != '0) dur_q <= dur_q - DUR_W'(1);
                // div = 0 is a rest: the counter never runs and beep stays low.
                if (div_q != '0) begin
                    if (half_q == div_q - DIV_W'(1)) begin
                        half_q <= '0;
                        beep   <= ~beep;
                    end else begin
                        half_q <= half_q + DIV_W'(1);
                    end
                end
            end
            if (state_d != PLAY) beep <= 1'b0;
        end
    end

    assign busy      = (state_q != IDLE);
    assign count     = 8'(cnt);
    assign state_dbg = state_q;

endmodule

// File: rtl/ahblite_tone_seq.sv
// AHB-Lite slave with NUM_CH queued square-wave tone channels. Holds the bus
// decode, the shared duration-tick prescaler, the read mux and the irq OR.
module ahblite_tone_seq
    import tone_seq_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 20,
    parameter int DUR_W      = 12,
    parameter int TICK_DIV   = 50000
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic [2:0]        HSIZE,
    input  logic [3:0]        HPROT,
    input  logic              HWRITE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic [31:0]       HRDATA,
    output logic              HRESP,
    output logic [NUM_CH-1:0] beep,
    output logic              irq
);

    localparam int TW = $clog2(TICK_DIV + 1);

    logic [TW-1:0] pres_q;
    logic          tick;
    logic          xfer, dp_valid, dp_write, wr_act;
    logic [3:0]    dp_addr;
    logic [1:0]    dp_ch, dp_off;
    logic [31:0]   ctrl_rd [4];
    logic [31:0]   stat_rd [4];
    logic [3:0]    irq_vec;
    ch_state_e     ch_state [4];
    logic          unused_bits;

    assign tick = (pres_q == TW'(TICK_DIV - 1));

    always_ff @(posedge HCLK) begin
        if (!HRESETn) pres_q <= '0;
        else          pres_q <= tick ? '0 : pres_q + TW'(1);
    end

    // Handshake: a transfer is accepted when HSEL & HTRANS[1] & HREADY are all
    // high at a clock edge; its data phase is the following cycle, which this
    // slave always completes (HREADYOUT=1) with write data taken from HWDATA.
    assign xfer = HSEL & HTRANS[1] & HREADY;

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
        end else begin
            dp_valid <= xfer;
            if (xfer) begin
                dp_write <= HWRITE;
                dp_addr  <= HADDR[5:2];
            end
        end
    end

    assign dp_ch  = dp_addr[3:2];
    assign dp_off = dp_addr[1:0];
    assign wr_act = dp_valid & dp_write;

    // Slots at or above NUM_CH have no channel: writes fall away, reads are 0.
    for (genvar i = 0; i < 4; i++) begin : g_ch
        if (i < NUM_CH) begin : g_on
            logic       en, ie, busy, empty, full, ovf, done, wr_here;
            logic [7:0] count;

            assign wr_here = wr_act & (dp_ch == 2'(i));

            tone_channel #(
                .FIFO_DEPTH(FIFO_DEPTH),
                .DIV_W     (DIV_W),
                .DUR_W     (DUR_W)
            ) u_ch (
                .HCLK      (HCLK),
                .HRESETn   (HRESETn),
                .tick      (tick),
                .ctrl_we   (wr_here & (dp_off == OFF_CTRL)),
                .ctrl_wdata(HWDATA[2:0]),
                .note_we   (wr_here & (dp_off == OFF_NOTE)),
                .note_div  (HWDATA[DIV_W-1:0]),
                .note_dur  (HWDATA[DUR_W+19:20]),
                .clr_we    (wr_here & (dp_off == OFF_CLR)),
                .clr_ovf   (HWDATA[CLR_OVF]),
                .clr_done  (HWDATA[CLR_DONE]),
                .en        (en),
                .done_ie   (ie),
                .busy      (busy),
                .empty     (empty),
                .full      (full),
                .ovf       (ovf),
                .done      (done),
                .count     (count),
                .beep      (beep[i]),
                .state_dbg (ch_state[i])
            );

            assign ctrl_rd[i] = {30'b0, ie, en};
            assign stat_rd[i] = {16'b0, count, 3'b0, done, ovf, full, empty, busy};
            assign irq_vec[i] = done & ie;
        end else begin : g_off
            assign ctrl_rd[i]  = '0;
            assign stat_rd[i]  = '0;
            assign irq_vec[i]  = 1'b0;
            assign ch_state[i] = IDLE;
        end
    end

    always_comb begin
        HRDATA = '0;
        if (dp_valid && !dp_write) begin
            case (dp_off)
                OFF_CTRL: HRDATA = ctrl_rd[dp_ch];
                OFF_STAT: HRDATA = stat_rd[dp_ch];
                default:  HRDATA = '0;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
    assign irq       = |irq_vec;

    assign unused_bits = ^{HSIZE, HPROT, HADDR[31:6], HADDR[1:0],
                           ch_state[0], ch_state[1], ch_state[2], ch_state[3]};

endmodule
